io_dispatch: RTL and testbench
==============================

# io_dispatch

Parametrised memory-mapped I/O dispatcher between the CPU core, block RAM, PS/2 keyboard receiver and seven-segment driver. It decodes a small I/O window at the top of the address space. Keyboard scancodes are buffered in a FIFO that the core drains by reading a data register. Core writes to the display register drive the seven-segment value, and every other access passes through to memory.

## Interface
Parameters:
- ADDR_W, 15, core address width
- DATA_W, 16, core data width; must be ≥ 8 + CNT_W, where CNT_W = clog2(FIFO_DEPTH)+1
- FIFO_DEPTH, 8, scancode FIFO entries; power of two, ≥ 2
- IO_BASE, 2^ADDR_W − 4, base of the 4-word I/O window

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- kbd_valid  in  1  one-cycle strobe: new scancode on kbd_code
- kbd_code  in  8  scancode from the PS/2 receiver
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_we  in  1  core write strobe
- core_re  in  1  core read strobe
- mem_rdata  in  DATA_W  block RAM read data (1-cycle latency)
- mem_we  out  1  write enable to RAM; gated off for I/O addresses
- core_rdata  out  DATA_W  read data returned to core
- sseg_value  out  DATA_W  value shown on the seven-segment display
- kbd_irq  out  1  keyboard data pending (see Configuration)

## Operation
Address map: everything outside IO_BASE..IO_BASE+3 is memory.
- IO_BASE+3: KBD_DATA (read only)
- IO_BASE+2: KBD_STATUS (read; a write clears overflow)
- IO_BASE+1: SSEG (read/write)
- IO_BASE+0: reserved; reads return 0, writes are ignored

Memory path:
- mem_we = core_we & ~io_hit, combinational.

KBD_DATA read:
- When FIFO is non-empty: returns {0, head} and pops the head.
- When FIFO is empty: returns 0 and pops nothing.

KBD_STATUS read:
- bit0 empty, bit1 full, bit2 overflow (sticky).
- bits [8 +: CNT_W] hold the entry count; all other bits are 0.

FIFO:
- Circular buffer with read/write pointers of clog2(FIFO_DEPTH) bits that wrap modulo depth, plus a count register.
- Push on kbd_valid.
- Push when full with no pop in the same cycle: scancode is dropped, overflow is set.
- Push and pop in the same cycle, any fill level including full: both happen; count is unchanged, no overflow.
- Overflow is cleared by any write to KBD_STATUS.
- Set and clear of overflow in the same cycle: set wins.

SSEG:
- A write loads core_wdata into sseg_value.
- A read returns sseg_value.

Read mux:
- Decode select and I/O read data are registered on the core_re edge, so I/O reads match RAM's 1-cycle latency.
- core_rdata = registered I/O value when the registered select is an I/O hit, else mem_rdata.
- The registered select holds until the next core_re.

Reset (rst_n low, asynchronous):
- Pointers, count, overflow, sseg_value, the read register and the select all clear to 0.
- core_rdata reads 0; kbd_irq is 0.
- Reset asserted mid-operation discards all FIFO contents immediately.

## Timing
- Read latency is 1 cycle for both memory and I/O: address and core_re at edge N, data valid on core_rdata after edge N+1.
- A pop takes effect at the same edge the data is captured. A back-to-back KBD_DATA read on the next cycle returns the next entry.
- A push is visible in KBD_STATUS and KBD_DATA on reads issued in the cycle after kbd_valid.
- kbd_irq follows ~empty from registered state, so it changes 1 cycle after a push or pop.
- mem_we is combinational, with zero added latency.

## Configuration
- IO_DISPATCH_IRQ_EN defined: kbd_irq = ~empty, registered.
- IO_DISPATCH_IRQ_EN undefined: kbd_irq is tied to 0 and no extra flop is built.
- FIFO and decode behaviour are identical in both builds.

## Test plan
- Reset, then read KBD_STATUS → 0x0001 (empty); core_rdata = 0 while rst_n is low.
- Push 0x1C, 0x32, 0x21, then read KBD_DATA ×4 → 0x001C, 0x0032, 0x0021, 0x0000; status returns to 0x0001.
- Push 9 codes with FIFO_DEPTH=8 → status 0x0806 (count 8, full, overflow). Then write KBD_STATUS and pop once → 0x0700.
- With FIFO full, kbd_valid coincides with a KBD_DATA read → oldest code is returned, new code is accepted, count stays 8, no overflow.
- Write 0xBEEF to SSEG → sseg_value = 0xBEEF, SSEG read returns 0xBEEF, mem_we stays 0. Write to 0x0100 → mem_we = 1.
- With IO_DISPATCH_IRQ_EN: push one code → kbd_irq rises 1 cycle later; pop → falls 1 cycle later. Without the macro: kbd_irq stays 0 throughout.

Source files
------------

// File: rtl/io_dispatch_if.sv
// Core-side bus of the I/O dispatcher: core address/data/strobes plus the RAM pass-through.
interface io_dispatch_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_we;
  logic              core_re;
  logic [DATA_W-1:0] core_rdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  modport master (
    output core_addr, core_wdata, core_we, core_re, mem_rdata,
    input  core_rdata, mem_we
  );

  modport slave (
    input  core_addr, core_wdata, core_we, core_re, mem_rdata,
    output core_rdata, mem_we
  );
endinterface

// File: rtl/io_dispatch.sv
// Memory-mapped I/O dispatcher: keyboard scancode FIFO, seven-segment register, RAM pass-through.
// Optional build macro IO_DISPATCH_IRQ_EN enables a registered keyboard-pending interrupt.
module io_dispatch #(
  parameter int                ADDR_W     = 15,
  parameter int                DATA_W     = 16,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] IO_BASE    = {{(ADDR_W-2){1'b1}}, 2'b00}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_code,
  io_dispatch_if.slave      bus,
  output logic [DATA_W-1:0] sseg_value,
  output logic              kbd_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] offset;
  logic              io_hit;
  logic [1:0]        reg_sel;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              ovf_clr;
  logic              sseg_wr;

  logic [DATA_W-1:0] io_rdata;
  logic [DATA_W-1:0] rd_q;
  logic              rd_sel;

  // Window is four words; any offset with upper bits set lies outside it.
  assign offset  = bus.core_addr - IO_BASE;
  assign io_hit  = (offset[ADDR_W-1:2] == '0);
  assign reg_sel = offset[1:0];

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop     = bus.core_re & io_hit & (reg_sel == 2'd3) & ~empty;
  assign push_ok = kbd_valid & (~full | pop);
  assign drop    = kbd_valid & full & ~pop;
  assign ovf_clr = bus.core_we & io_hit & (reg_sel == 2'd2);
  assign sseg_wr = bus.core_we & io_hit & (reg_sel == 2'd1);

  assign bus.mem_we = bus.core_we & ~io_hit;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= kbd_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sseg_value <= '0;
    else if (sseg_wr) sseg_value <= bus.core_wdata;
  end

  always_comb begin
    io_rdata = '0;
    case (reg_sel)
      2'd3: if (!empty) io_rdata[7:0] = fifo_mem[rd_ptr];
      2'd2: begin
        io_rdata[0]          = empty;
        io_rdata[1]          = full;
        io_rdata[2]          = overflow;
        io_rdata[8 +: CNT_W] = count;
      end
      2'd1:    io_rdata = sseg_value;
      default: io_rdata = '0;
    endcase
  end

  // Registering on core_re aligns I/O reads with the RAM's one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel <= 1'b0;
      rd_q   <= '0;
    end else if (bus.core_re) begin
      rd_sel <= io_hit;
      rd_q   <= io_rdata;
    end
  end

  assign bus.core_rdata = !rst_n ? '0 : (rd_sel ? rd_q : bus.mem_rdata);

`ifdef IO_DISPATCH_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= ~empty;
  end
  assign kbd_irq = irq_q;
`else
  assign kbd_irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_dispatch.sv
// Self-checking bench for io_dispatch: vector table plus hand-written FIFO/reset/irq sequences.
module tb_io_dispatch;
  localparam logic [14:0] A_RSV  = 15'h7FFC;
  localparam logic [14:0] A_SSEG = 15'h7FFD;
  localparam logic [14:0] A_STAT = 15'h7FFE;
  localparam logic [14:0] A_DATA = 15'h7FFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kbd_valid;
  logic [7:0]  kbd_code;
  logic [15:0] sseg_value;
  logic        kbd_irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sb_q [$];

  io_dispatch_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  io_dispatch #(.ADDR_W(15), .DATA_W(16), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kbd_valid  (kbd_valid),
    .kbd_code   (kbd_code),
    .bus        (bus),
    .sseg_value (sseg_value),
    .kbd_irq    (kbd_irq)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, data derived from the address.
  always @(posedge clk) begin
    if (bus.core_re) bus.mem_rdata <= {1'b0, bus.core_addr} ^ 16'h5A5A;
  end

  typedef struct {
    logic        kv;
    logic [7:0]  code;
    logic        we;
    logic        re;
    logic [14:0] addr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic kv, input logic [7:0] code, input logic we,
                              input logic re, input logic [14:0] addr, input logic [15:0] wd,
                              input logic [15:0] exp);
    vec_t v;
    v.kv = kv; v.code = code; v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic kv, input logic [7:0] code, input logic we, input logic re,
                      input logic [14:0] addr, input logic [15:0] wd, input logic [15:0] exp,
                      input string nm);
    logic [15:0] e;
    @(negedge clk);
    kbd_valid = kv; kbd_code = code;
    bus.core_we = we; bus.core_re = re; bus.core_addr = addr; bus.core_wdata = wd;
    #1;
    if (we) check({nm, "/mem_we"}, 32'(bus.mem_we), 32'(addr < A_RSV));
    if (re) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (re) begin
      e = sb_q.pop_front();
      check(nm, 32'(bus.core_rdata), 32'(e));
    end
    kbd_valid = 1'b0; bus.core_we = 1'b0; bus.core_re = 1'b0;
  endtask

  task automatic push(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0, 15'h0000, 16'h0, 16'h0, "push");
  endtask

  task automatic rd(input logic [14:0] a, input logic [15:0] exp, input string nm);
    step(1'b0, 8'h00, 1'b0, 1'b1, a, 16'h0, exp, nm);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 15'h0000, 16'h0, 16'h0, "idle");
  endtask

  logic irq_hi;
  logic [7:0] drain [8];

  initial begin
`ifdef IO_DISPATCH_IRQ_EN
    irq_hi = 1'b1;
`else
    irq_hi = 1'b0;
`endif
    rst_n = 1'b0; kbd_valid = 1'b0; kbd_code = 8'h00;
    bus.core_we = 1'b0; bus.core_re = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.mem_rdata = 16'hA5A5;
    #2;
    check("rst_rdata", 32'(bus.core_rdata), 32'h0);
    check("rst_sseg", 32'(sseg_value), 32'h0);
    check("rst_irq", 32'(kbd_irq), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = mk(0, 8'h00, 0, 1, A_STAT, 16'h0,    16'h0001);
    vecs[1]  = mk(1, 8'h1C, 0, 0, 15'h0,  16'h0,    16'h0);
    vecs[2]  = mk(1, 8'h32, 0, 0, 15'h0,  16'h0,    16'h0);
    vecs[3]  = mk(1, 8'h21, 0, 0, 15'h0,  16'h0,    16'h0);
    vecs[4]  = mk(0, 8'h00, 0, 1, A_STAT, 16'h0,    16'h0300);
    vecs[5]  = mk(0, 8'h00, 0, 1, A_DATA, 16'h0,    16'h001C);
    vecs[6]  = mk(0, 8'h00, 0, 1, A_DATA, 16'h0,    16'h0032);
    vecs[7]  = mk(0, 8'h00, 0, 1, A_DATA, 16'h0,    16'h0021);
    vecs[8]  = mk(0, 8'h00, 0, 1, A_DATA, 16'h0,    16'h0000);
    vecs[9]  = mk(0, 8'h00, 0, 1, A_STAT, 16'h0,    16'h0001);
    vecs[10] = mk(0, 8'h00, 1, 0, A_SSEG, 16'hBEEF, 16'h0);
    vecs[11] = mk(0, 8'h00, 0, 1, A_SSEG, 16'h0,    16'hBEEF);
    vecs[12] = mk(0, 8'h00, 0, 1, A_RSV,  16'h0,    16'h0000);
    vecs[13] = mk(0, 8'h00, 1, 0, A_RSV,  16'h1234, 16'h0);
    vecs[14] = mk(0, 8'h00, 0, 1, A_SSEG, 16'h0,    16'hBEEF);
    vecs[15] = mk(0, 8'h00, 0, 1, 15'h0100, 16'h0,  16'h5B5A);
    vecs[16] = mk(0, 8'h00, 1, 0, 15'h0100, 16'h7777, 16'h0);

    foreach (vecs[i])
      step(vecs[i].kv, vecs[i].code, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd,
           vecs[i].exp, $sformatf("vec%0d", i));
    check("sseg_value", 32'(sseg_value), 32'hBEEF);

    // Overflow: nine pushes into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) push(8'h40 + 8'(i));
    rd(A_STAT, 16'h0806, "stat_ovf");
    step(0, 8'h00, 1, 0, A_STAT, 16'h0, 16'h0, "clr_ovf");
    rd(A_DATA, 16'h0040, "pop_after_ovf");
    rd(A_STAT, 16'h0700, "stat_7");
    push(8'h50);
    rd(A_STAT, 16'h0802, "stat_full");
    // Drop and clear in the same cycle: overflow must stay set.
    step(1, 8'h60, 1, 0, A_STAT, 16'h0, 16'h0, "drop_and_clr");
    rd(A_STAT, 16'h0806, "stat_set_wins");
    step(0, 8'h00, 1, 0, A_STAT, 16'h0, 16'h0, "clr_ovf2");
    rd(A_STAT, 16'h0802, "stat_cleared");
    // Push and pop together while full.
    step(1, 8'h51, 0, 1, A_DATA, 16'h0, 16'h0041, "full_push_pop");
    rd(A_STAT, 16'h0802, "stat_full_pp");
    drain = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h50, 8'h51};
    foreach (drain[i]) rd(A_DATA, {8'h00, drain[i]}, $sformatf("drain%0d", i));
    rd(A_DATA, 16'h0000, "drain_empty");
    rd(A_STAT, 16'h0001, "stat_drained");

    // Interrupt timing: one cycle behind the push and the pop.
    push(8'h77);
    check("irq_push_same", 32'(kbd_irq), 32'h0);
    idle();
    check("irq_push_next", 32'(kbd_irq), 32'(irq_hi));
    rd(A_DATA, 16'h0077, "irq_pop");
    check("irq_pop_same", 32'(kbd_irq), 32'(irq_hi));
    idle();
    check("irq_pop_next", 32'(kbd_irq), 32'h0);

    // Asynchronous reset mid-operation discards FIFO contents.
    push(8'h11);
    push(8'h22);
    step(0, 8'h00, 1, 0, A_SSEG, 16'h1357, 16'h0, "sseg_pre_rst");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rdata", 32'(bus.core_rdata), 32'h0);
    check("midrst_sseg", 32'(sseg_value), 32'h0);
    check("midrst_irq", 32'(kbd_irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_STAT, 16'h0001, "post_rst_stat");
    rd(A_DATA, 16'h0000, "post_rst_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
